// File: rtl/voter_pkg.sv
// Shared types and width helpers for the majority vote filter.
package voter_pkg;

  typedef enum logic [1:0] {S_INIT, S_STABLE, S_PEND} state_t;

  localparam int DEF_N_VOTERS   = 5;
  localparam int DEF_STABLE_CNT = 4;
  localparam int DEF_FAULT_LIMIT = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int x;
    res = 0;
    x = value - 1;
    while (x > 0) begin
      res = res + 1;
      x = x >> 1;
    end
    return res;
  endfunction

  // Bits needed to hold 0..max_value, never less than one.
  function automatic int cnt_width(input int max_value);
    int w;
    w = clog2(max_value + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_ONES_W = cnt_width(DEF_N_VOTERS);

endpackage

// File: rtl/vote_popcount.sv
// Combinational ones counter over the voter inputs.
module vote_popcount #(
  parameter int N = 5,
  parameter int W = voter_pkg::cnt_width(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/majority_vote_filter.sv
// Registered N-of-M voter with consecutive-sample debounce and sticky per-voter fault flags.
module majority_vote_filter
  import voter_pkg::*;
#(
  parameter int N_VOTERS    = DEF_N_VOTERS,
  parameter int THRESHOLD   = (N_VOTERS + 1) / 2,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter int FAULT_LIMIT = DEF_FAULT_LIMIT,
  localparam int CW = cnt_width(N_VOTERS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [N_VOTERS-1:0] votes,
  input  logic                clear_faults,
  output logic                out_valid,
  output logic                vote_raw,
  output logic [CW-1:0]       ones_cnt,
  output logic                unanimous,
  output logic                vote_out,
  output logic [N_VOTERS-1:0] fault
);

  localparam int DW = cnt_width(STABLE_CNT);
  localparam int MW = cnt_width(FAULT_LIMIT);
  localparam logic [CW-1:0] THR      = CW'(THRESHOLD);
  localparam logic [CW-1:0] ALL_ONES = CW'(N_VOTERS);
  localparam logic [DW-1:0] D_LAST   = DW'(STABLE_CNT - 1);
  localparam logic [MW-1:0] M_LIM    = MW'(FAULT_LIMIT);
  localparam logic [MW-1:0] M_PRE    = MW'(FAULT_LIMIT - 1);

  logic [CW-1:0] ones_w;
  logic          raw_w;
  logic          unan_w;

  vote_popcount #(.N(N_VOTERS), .W(CW)) u_popcount (
    .bits  (votes),
    .count (ones_w)
  );

  assign raw_w  = (ones_w >= THR);
  assign unan_w = (ones_w == '0) || (ones_w == ALL_ONES);

  state_t        state_q;
  logic [DW-1:0] dcnt_q;
  logic          out_valid_q, vote_raw_q, unan_q, vote_out_q;
  logic [CW-1:0] ones_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      dcnt_q      <= '0;
      out_valid_q <= 1'b0;
      vote_raw_q  <= 1'b0;
      ones_q      <= '0;
      unan_q      <= 1'b0;
      vote_out_q  <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        vote_raw_q <= raw_w;
        ones_q     <= ones_w;
        unan_q     <= unan_w;
        case (state_q)
          S_INIT: begin
            vote_out_q <= raw_w;
            dcnt_q     <= '0;
            state_q    <= S_STABLE;
          end
          S_STABLE: begin
            if (raw_w != vote_out_q) begin
              dcnt_q <= DW'(1);
              // A one-sample debounce flips straight away without visiting S_PEND.
              if (STABLE_CNT == 1) vote_out_q <= raw_w;
              else                 state_q    <= S_PEND;
            end
          end
          S_PEND: begin
            if (raw_w == vote_out_q) begin
              dcnt_q  <= '0;
              state_q <= S_STABLE;
            end else if (dcnt_q == D_LAST) begin
              vote_out_q <= raw_w;
              dcnt_q     <= '0;
              state_q    <= S_STABLE;
            end else begin
              dcnt_q <= dcnt_q + DW'(1);
            end
          end
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  // Each voter is judged against the raw vote of the same sample, not the debounced output.
  logic [MW-1:0]       mcnt_q [N_VOTERS];
  logic [MW-1:0]       mcnt_d [N_VOTERS];
  logic [N_VOTERS-1:0] fault_q, fault_d, mis_w;

  for (genvar gi = 0; gi < N_VOTERS; gi++) begin : g_voter
    assign mis_w[gi]   = votes[gi] ^ raw_w;
    assign mcnt_d[gi]  = clear_faults            ? '0 :
                         !in_valid               ? mcnt_q[gi] :
                         !mis_w[gi]              ? '0 :
                         (mcnt_q[gi] == M_LIM)   ? mcnt_q[gi] :
                                                   mcnt_q[gi] + MW'(1);
    assign fault_d[gi] = clear_faults ? 1'b0 :
                         fault_q[gi] | (in_valid & mis_w[gi] & (mcnt_q[gi] == M_PRE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      for (int i = 0; i < N_VOTERS; i++) mcnt_q[i] <= '0;
    end else begin
      fault_q <= fault_d;
      for (int i = 0; i < N_VOTERS; i++) mcnt_q[i] <= mcnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign vote_raw  = vote_raw_q;
  assign ones_cnt  = ones_q;
  assign unanimous = unan_q;
  assign vote_out  = vote_out_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_majority_vote_filter.sv
// Checks two filter instances (5-voter default and 7-voter fast debounce) against a sample-level model.
module tb_majority_vote_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv5, cf5, ov5, raw5, un5, vo5;
  logic [4:0] v5, f5;
  logic [2:0] ones5;

  logic       iv7, cf7, ov7, raw7, un7, vo7;
  logic [6:0] v7, f7;
  logic [2:0] ones7;

  majority_vote_filter dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .votes(v5), .clear_faults(cf5),
    .out_valid(ov5), .vote_raw(raw5), .ones_cnt(ones5), .unanimous(un5),
    .vote_out(vo5), .fault(f5)
  );

  majority_vote_filter #(.N_VOTERS(7), .THRESHOLD(5), .STABLE_CNT(1), .FAULT_LIMIT(8)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv7), .votes(v7), .clear_faults(cf7),
    .out_valid(ov7), .vote_raw(raw7), .ones_cnt(ones7), .unanimous(un7),
    .vote_out(vo7), .fault(f7)
  );

  int total = 0;
  int bad   = 0;

  // Model configuration and state, index 0 = dut5, 1 = dut7.
  int NV [2] = '{5, 7};
  int TH [2] = '{3, 5};
  int SC [2] = '{4, 1};
  int FL [2] = '{8, 8};

  bit          m_first [2];
  bit          m_vout  [2];
  int          m_run   [2];
  bit          m_ov    [2];
  bit          m_raw   [2];
  bit          m_un    [2];
  int          m_ones  [2];
  int          m_mc    [2][32];
  logic [31:0] m_fault [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_first[d] = 1'b1;
      m_vout[d]  = 1'b0;
      m_run[d]   = 0;
      m_ov[d]    = 1'b0;
      m_raw[d]   = 1'b0;
      m_un[d]    = 1'b0;
      m_ones[d]  = 0;
      m_fault[d] = '0;
      for (int i = 0; i < 32; i++) m_mc[d][i] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit valid, input logic [31:0] votes, input bit clr);
    int pc;
    bit r;
    m_ov[d] = valid;
    if (clr) begin
      m_fault[d] = '0;
      for (int i = 0; i < 32; i++) m_mc[d][i] = 0;
    end
    if (valid) begin
      pc = $countones(votes);
      r  = (pc >= TH[d]);
      m_raw[d]  = r;
      m_ones[d] = pc;
      m_un[d]   = (pc == 0) || (pc == NV[d]);
      if (m_first[d]) begin
        m_vout[d]  = r;
        m_first[d] = 1'b0;
        m_run[d]   = 0;
      end else if (r != m_vout[d]) begin
        m_run[d]++;
        if (m_run[d] >= SC[d]) begin
          m_vout[d] = r;
          m_run[d]  = 0;
        end
      end else begin
        m_run[d] = 0;
      end
      if (!clr) begin
        for (int i = 0; i < NV[d]; i++) begin
          if (votes[i] != r) begin
            if (m_mc[d][i] < FL[d]) m_mc[d][i]++;
            if (m_mc[d][i] == FL[d]) m_fault[d][i] = 1'b1;
          end else begin
            m_mc[d][i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ov5"},    32'(ov5),   32'(m_ov[0]));
    chk({tag, ".raw5"},   32'(raw5),  32'(m_raw[0]));
    chk({tag, ".ones5"},  32'(ones5), 32'(m_ones[0]));
    chk({tag, ".un5"},    32'(un5),   32'(m_un[0]));
    chk({tag, ".vo5"},    32'(vo5),   32'(m_vout[0]));
    chk({tag, ".f5"},     32'(f5),    {27'd0, m_fault[0][4:0]});
    chk({tag, ".ov7"},    32'(ov7),   32'(m_ov[1]));
    chk({tag, ".raw7"},   32'(raw7),  32'(m_raw[1]));
    chk({tag, ".ones7"},  32'(ones7), 32'(m_ones[1]));
    chk({tag, ".un7"},    32'(un7),   32'(m_un[1]));
    chk({tag, ".vo7"},    32'(vo7),   32'(m_vout[1]));
    chk({tag, ".f7"},     32'(f7),    {25'd0, m_fault[1][6:0]});
  endtask

  task automatic step(input bit a5, input logic [4:0] x5, input bit c5,
                      input bit a7, input logic [6:0] x7, input bit c7, input string tag);
    @(negedge clk);
    iv5 = a5; v5 = x5; cf5 = c5;
    iv7 = a7; v7 = x7; cf7 = c7;
    @(posedge clk);
    model_step(0, a5, {27'd0, x5}, c5);
    model_step(1, a7, {25'd0, x7}, c7);
    #1;
    check_all(tag);
    $display("step %s: v5=%b ov5=%b vo5=%b f5=%b | v7=%b ov7=%b vo7=%b", tag, x5, ov5, vo5, f5, x7, ov7, vo7);
  endtask

  task automatic s5(input bit a, input logic [4:0] x, input bit c, input string tag);
    step(a, x, c, 1'b0, 7'd0, 1'b0, tag);
  endtask

  task automatic s7(input bit a, input logic [6:0] x, input string tag);
    step(1'b0, 5'd0, 1'b0, a, x, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] base;
    rst_n = 1'b0;
    iv5 = 1'b0; v5 = '0; cf5 = 1'b0;
    iv7 = 1'b0; v7 = '0; cf7 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first sample after reset loads vote_out directly
    s5(1, 5'b00111, 0, "t1");
    chk("t1.ones_const", 32'(ones5), 32'd3);
    chk("t1.vo_const",   32'(vo5),   32'd1);
    chk("t1.un_const",   32'(un5),   32'd0);

    // 2: drive to stable 0, interrupted run, then full 4-sample flip
    for (int i = 0; i < 4; i++) s5(1, 5'b00000, 0, "t2.to0");
    chk("t2.vo_is0", 32'(vo5), 32'd0);
    for (int i = 0; i < 3; i++) s5(1, 5'b11100, 0, "t2.run3");
    s5(1, 5'b00001, 0, "t2.break");
    chk("t2.vo_held", 32'(vo5), 32'd0);
    for (int i = 0; i < 3; i++) s5(1, 5'b11100, 0, "t2.run");
    chk("t2.vo_pre", 32'(vo5), 32'd0);
    s5(1, 5'b11100, 0, "t2.flip");
    chk("t2.vo_flip", 32'(vo5), 32'd1);

    // 3: gaps between valid samples neither advance nor reset the debounce
    for (int i = 0; i < 4; i++) begin
      s5(1, 5'b00000, 0, "t3.valid");
      if (i < 3) s5(0, 5'b11111, 0, "t3.gap");
    end
    chk("t3.vo_flip", 32'(vo5), 32'd0);

    // 4: voters 0 and 4 persistently disagree
    s5(1, 5'b00000, 1, "t4.clr");
    for (int i = 0; i < 7; i++) s5(1, 5'b01110, 0, "t4.mis");
    chk("t4.f_pre", 32'(f5), 32'd0);
    s5(1, 5'b01110, 0, "t4.mis8");
    chk("t4.f_set", 32'(f5), 32'b10001);
    for (int i = 0; i < 2; i++) s5(1, 5'b01110, 0, "t4.more");
    for (int i = 0; i < 3; i++) s5(1, 5'b11111, 0, "t4.agree");
    chk("t4.f_sticky", 32'(f5), 32'b10001);

    // 5: clear wins over a simultaneous mismatching sample
    s5(1, 5'b01110, 1, "t5.clr");
    chk("t5.f_clr", 32'(f5), 32'd0);
    for (int i = 0; i < 7; i++) s5(1, 5'b01110, 0, "t5.mis");
    chk("t5.f_pre", 32'(f5), 32'd0);
    s5(1, 5'b01110, 0, "t5.mis8");
    chk("t5.f_set", 32'(f5), 32'b10001);

    // 6: async reset while a flip is pending
    s5(1, 5'b00000, 0, "t6.pend1");
    s5(1, 5'b00000, 0, "t6.pend2");
    #2;
    rst_n = 1'b0;
    iv5 = 1'b0; iv7 = 1'b0;
    model_reset();
    #1;
    check_all("t6.async");
    chk("t6.vo_zero", 32'(vo5), 32'd0);
    chk("t6.f_zero",  32'(f5),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s5(1, 5'b11111, 0, "t6.load");
    chk("t6.vo_load", 32'(vo5), 32'd1);
    chk("t6.un_load", 32'(un5), 32'd1);

    // 7-voter, threshold 5, no debounce
    s7(1, 7'b0000000, "t7.init");
    s7(1, 7'b0001111, "t7.cnt4");
    chk("t7.raw4", 32'(raw7), 32'd0);
    chk("t7.vo4",  32'(vo7),  32'd0);
    s7(1, 7'b0011111, "t7.cnt5");
    chk("t7.raw5", 32'(raw7), 32'd1);
    chk("t7.vo5",  32'(vo7),  32'd1);

    // Randomised traffic on both instances, biased toward near-unanimous patterns
    for (int n = 0; n < 400; n++) begin
      logic [4:0] x5;
      logic [6:0] x7;
      base = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
      rv   = ($urandom_range(0, 2) == 0) ? $urandom : (base ^ ($urandom & $urandom & $urandom));
      x5 = rv[4:0];
      x7 = rv[11:5];
      step($urandom_range(0, 3) != 0, x5, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0, x7, $urandom_range(0, 40) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
